// File: rtl/cr16_ctrl_fsm_v2_pkg.sv
// Shared constants for the CR16 control FSM: opcode/extension codes, condition codes,
// flag bit positions, state encoding and the immediate-extension rule.
package cr16_ctrl_fsm_v2_pkg;

  localparam logic [3:0] OPC_NOP   = 4'h0;
  localparam logic [3:0] OPC_EXT   = 4'h4;
  localparam logic [3:0] OPC_CMP   = 4'hB;
  localparam logic [3:0] OPC_BCOND = 4'hC;

  localparam logic [3:0] EXT_LOAD  = 4'h0;
  localparam logic [3:0] EXT_STORE = 4'h4;
  localparam logic [3:0] EXT_JCOND = 4'hC;

  localparam logic [3:0] CC_EQ = 4'h0;
  localparam logic [3:0] CC_NE = 4'h1;
  localparam logic [3:0] CC_CS = 4'h2;
  localparam logic [3:0] CC_CC = 4'h3;
  localparam logic [3:0] CC_HI = 4'h4;
  localparam logic [3:0] CC_LS = 4'h5;
  localparam logic [3:0] CC_GT = 4'h6;
  localparam logic [3:0] CC_LE = 4'h7;
  localparam logic [3:0] CC_FS = 4'h8;
  localparam logic [3:0] CC_FC = 4'h9;
  localparam logic [3:0] CC_LO = 4'hA;
  localparam logic [3:0] CC_HS = 4'hB;
  localparam logic [3:0] CC_LT = 4'hC;
  localparam logic [3:0] CC_GE = 4'hD;
  localparam logic [3:0] CC_UC = 4'hE;
  localparam logic [3:0] CC_NV = 4'hF;

  localparam int FLAG_Z = 4;
  localparam int FLAG_C = 3;
  localparam int FLAG_F = 2;
  localparam int FLAG_L = 1;
  localparam int FLAG_N = 0;

  typedef enum logic [2:0] {
    S_FETCH   = 3'd0,
    S_DECODE  = 3'd1,
    S_EXEC    = 3'd2,
    S_STORE   = 3'd3,
    S_LD_ADDR = 3'd4,
    S_LD_WB   = 3'd5,
    S_HALT    = 3'd6
  } state_e;

  // Logical/unsigned-style operations take a zero-extended immediate.
  function automatic logic imm_is_zext(input logic [3:0] op);
    case (op)
      4'h1, 4'h2, 4'h3, 4'h4, 4'h8, 4'hC, 4'hE, 4'hF: return 1'b1;
      default:                                        return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/cr16_ctrl_fsm_v2_if.sv
// Instruction/data memory handshake between the control FSM and the memory/IR side.
interface cr16_ctrl_fsm_v2_if;
  logic        mem_req;
  logic        mem_we;
  logic        ls_ctrl;
  logic        mem_ready;
  logic [15:0] instr;
  logic [15:0] ir_reg;

  modport master (output mem_req, mem_we, ls_ctrl, input mem_ready, instr, ir_reg);
  modport slave  (input mem_req, mem_we, ls_ctrl, output mem_ready, instr, ir_reg);
endinterface

// File: rtl/cr16_ctrl_fsm_v2_cond_eval.sv
// Condition-code evaluator shared by the Bcond and Jcond paths.
module cr16_ctrl_fsm_v2_cond_eval
  import cr16_ctrl_fsm_v2_pkg::*;
(
  input  logic [4:0] flags,
  input  logic [3:0] cond,
  output logic       taken
);
  logic z, c, f, l, n;

  assign z = flags[FLAG_Z];
  assign c = flags[FLAG_C];
  assign f = flags[FLAG_F];
  assign l = flags[FLAG_L];
  assign n = flags[FLAG_N];

  always_comb begin
    taken = 1'b0;
    case (cond)
      CC_EQ: taken = z;
      CC_NE: taken = !z;
      CC_CS: taken = c;
      CC_CC: taken = !c;
      CC_HI: taken = l;
      CC_LS: taken = !l;
      CC_GT: taken = n;
      CC_LE: taken = !n;
      CC_FS: taken = f;
      CC_FC: taken = !f;
      CC_LO: taken = !l && !z;
      CC_HS: taken = l || z;
      CC_LT: taken = !n && !z;
      CC_GE: taken = n || z;
      CC_UC: taken = 1'b1;
      default: taken = 1'b0;
    endcase
  end
endmodule

// File: rtl/cr16_ctrl_fsm_v2.sv
// Multi-cycle fetch/decode/execute controller for the CR16-style ISA with memory wait
// states, debug halt/step, retire-count pause and a sticky illegal-extension flag.
module cr16_ctrl_fsm_v2
  import cr16_ctrl_fsm_v2_pkg::*;
#(
  parameter  int DATA_W      = 16,
  parameter  int NREGS       = 16,
  parameter  int PAUSE_AFTER = 0,
  parameter  int CNT_W       = 16,
  localparam int REG_AW      = $clog2(NREGS)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [4:0]            flags,
  cr16_ctrl_fsm_v2_if.master    bus,
  input  logic                  dbg_halt,
  input  logic                  dbg_step,
  output logic                  ir_en,
  output logic                  pc_en,
  output logic                  pc_load,
  output logic                  pc_mux_ctrl,
  output logic [DATA_W-1:0]     disp,
  output logic                  reg_we,
  output logic [NREGS-1:0]      reg_en,
  output logic [REG_AW-1:0]     rsrc,
  output logic [REG_AW-1:0]     rdest,
  output logic [3:0]            op,
  output logic [DATA_W-1:0]     imm,
  output logic                  imm_en,
  output logic                  alu_mux_ctrl,
  output logic                  halted,
  output logic                  illegal,
  output logic [CNT_W-1:0]      instr_count
);

  function automatic logic [DATA_W-1:0] sext8(input logic signed [7:0] v);
    logic signed [DATA_W-1:0] w;
    w = v;
    return w;
  endfunction

  function automatic logic [DATA_W-1:0] zext8(input logic [7:0] v);
    return DATA_W'(v);
  endfunction

  state_e             state, state_nxt;
  logic               step_run, pause_hold, step_go, illegal_set, taken, pause_hit;
  logic [3:0]         opc, ext, op_sel;
  logic [REG_AW-1:0]  ins_src, ins_dst, ir_src, ir_dst;
  logic [CNT_W-1:0]   count_inc;
  logic               ir_unused;

  assign opc       = bus.instr[15:12];
  assign ext       = bus.instr[7:4];
  assign op_sel    = (opc == OPC_NOP) ? ext : opc;
  assign ins_src   = REG_AW'(bus.instr[3:0]);
  assign ins_dst   = REG_AW'(bus.instr[11:8]);
  assign ir_src    = REG_AW'(bus.ir_reg[3:0]);
  assign ir_dst    = REG_AW'(bus.ir_reg[11:8]);
  assign ir_unused = ^{bus.ir_reg[15:12], bus.ir_reg[7:4]};
  assign count_inc = instr_count + 1'b1;
  assign pause_hit = (PAUSE_AFTER != 0) && (count_inc == CNT_W'(PAUSE_AFTER));

  cr16_ctrl_fsm_v2_cond_eval u_cond (
    .flags (flags),
    .cond  (bus.instr[11:8]),
    .taken (taken)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= S_FETCH;
      instr_count <= '0;
      illegal     <= 1'b0;
      step_run    <= 1'b0;
      pause_hold  <= 1'b0;
    end else begin
      state <= state_nxt;
      if (pc_en) begin
        instr_count <= count_inc;
        step_run    <= 1'b0;
      end else if (step_go) begin
        step_run <= 1'b1;
      end
      // A pause halt stays sticky until reset; only single steps escape it.
      if (pc_en && pause_hit) pause_hold <= 1'b1;
      if (illegal_set)        illegal    <= 1'b1;
    end
  end

  always_comb begin
    state_nxt    = S_FETCH;
    bus.mem_req  = 1'b0;
    bus.mem_we   = 1'b0;
    bus.ls_ctrl  = 1'b0;
    ir_en        = 1'b0;
    pc_en        = 1'b0;
    pc_load      = 1'b0;
    pc_mux_ctrl  = 1'b0;
    disp         = '0;
    reg_we       = 1'b0;
    reg_en       = '0;
    rsrc         = '0;
    rdest        = '0;
    op           = '0;
    imm          = '0;
    imm_en       = 1'b0;
    alu_mux_ctrl = 1'b0;
    halted       = 1'b0;
    illegal_set  = 1'b0;
    step_go      = 1'b0;
    // Outputs are forced to their reset values for as long as reset is held.
    if (reset) begin
      case (state)
        S_FETCH: begin
          bus.mem_req = 1'b1;
          ir_en       = 1'b1;
          state_nxt   = bus.mem_ready ? S_DECODE : S_FETCH;
        end
        S_DECODE: begin
          rsrc  = ins_src;
          rdest = ins_dst;
          if (opc == OPC_EXT && ext == EXT_STORE)     state_nxt = S_STORE;
          else if (opc == OPC_EXT && ext == EXT_LOAD) state_nxt = S_LD_ADDR;
          else                                        state_nxt = S_EXEC;
        end
        S_EXEC: begin
          rsrc   = ins_src;
          rdest  = ins_dst;
          op     = op_sel;
          imm_en = (opc != OPC_NOP);
          imm    = imm_is_zext(op_sel) ? zext8(bus.instr[7:0]) : sext8(bus.instr[7:0]);
          pc_en  = 1'b1;
          if (opc == OPC_BCOND) begin
            disp        = sext8(bus.instr[7:0]);
            pc_mux_ctrl = taken;
          end else if (opc == OPC_EXT) begin
            if (ext == EXT_JCOND) pc_load     = taken;
            else                  illegal_set = 1'b1;
          end else if (op_sel != OPC_CMP && op_sel != OPC_NOP) begin
            reg_we = 1'b1;
            reg_en = NREGS'(1) << ins_dst;
          end
        end
        S_STORE: begin
          rsrc        = ir_src;
          rdest       = ir_dst;
          bus.ls_ctrl = 1'b1;
          bus.mem_req = 1'b1;
          bus.mem_we  = 1'b1;
          pc_en       = bus.mem_ready;
          state_nxt   = S_STORE;
        end
        S_LD_ADDR: begin
          rsrc        = ir_src;
          bus.ls_ctrl = 1'b1;
          bus.mem_req = 1'b1;
          state_nxt   = bus.mem_ready ? S_LD_WB : S_LD_ADDR;
        end
        S_LD_WB: begin
          rdest        = ir_dst;
          alu_mux_ctrl = 1'b1;
          reg_we       = 1'b1;
          reg_en       = NREGS'(1) << ir_dst;
          pc_en        = 1'b1;
        end
        S_HALT: begin
          halted = 1'b1;
          if (dbg_step) begin
            step_go   = 1'b1;
            state_nxt = S_FETCH;
          end else if (!dbg_halt && !pause_hold) begin
            state_nxt = S_FETCH;
          end else begin
            state_nxt = S_HALT;
          end
        end
        default: state_nxt = S_FETCH;
      endcase
      // Retire boundary: the only point where a halt request is honoured.
      if (pc_en) state_nxt = (dbg_halt || pause_hit || step_run) ? S_HALT : S_FETCH;
    end
  end

endmodule

// File: tb/tb_cr16_ctrl_fsm_v2.sv
// Randomized bench for cr16_ctrl_fsm_v2 against an instruction-level timeline model.
module tb_cr16_ctrl_fsm_v2;
  localparam int PA = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  flags;
  logic        dbg_halt, dbg_step;
  logic        ir_en, pc_en, pc_load, pc_mux_ctrl, reg_we, imm_en, alu_mux_ctrl, halted, illegal;
  logic [15:0] disp, imm, reg_en, instr_count;
  logic [3:0]  rsrc, rdest, op;

  cr16_ctrl_fsm_v2_if bus();

  cr16_ctrl_fsm_v2 #(.DATA_W(16), .NREGS(16), .PAUSE_AFTER(PA), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .flags(flags), .bus(bus),
    .dbg_halt(dbg_halt), .dbg_step(dbg_step),
    .ir_en(ir_en), .pc_en(pc_en), .pc_load(pc_load), .pc_mux_ctrl(pc_mux_ctrl),
    .disp(disp), .reg_we(reg_we), .reg_en(reg_en), .rsrc(rsrc), .rdest(rdest),
    .op(op), .imm(imm), .imm_en(imm_en), .alu_mux_ctrl(alu_mux_ctrl),
    .halted(halted), .illegal(illegal), .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // model state
  int  m_count;
  bit  m_ill, m_hold, m_halted, m_step;

  // expected per-instruction results
  int          e_kind;  // 0 exec, 1 store, 2 load
  logic [3:0]  e_op;
  logic [15:0] e_imm, e_reg_en, e_disp;
  bit          e_imm_en, e_reg_we, e_pc_mux, e_pc_load, e_ill;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Even codes test a base predicate; the odd code right after it is its complement.
  function automatic bit taken_ref(input logic [3:0] c, input logic [4:0] f);
    bit z, cy, ff, l, n, base;
    z = f[4]; cy = f[3]; ff = f[2]; l = f[1]; n = f[0];
    case (c[3:1])
      3'd0: base = z;
      3'd1: base = cy;
      3'd2: base = l;
      3'd3: base = n;
      3'd4: base = ff;
      3'd5: base = !l && !z;
      3'd6: base = !n && !z;
      default: base = 1'b1;
    endcase
    return c[0] ? !base : base;
  endfunction

  task automatic predict(input logic [15:0] ins, input logic [4:0] fl);
    logic [3:0] hi, ex;
    hi = ins[15:12];
    ex = ins[7:4];
    e_op     = (hi == 4'h0) ? ex : hi;
    e_imm_en = (hi != 4'h0);
    e_imm    = (e_op inside {4'h1, 4'h2, 4'h3, 4'h4, 4'h8, 4'hC, 4'hE, 4'hF}) ?
               {8'h00, ins[7:0]} : {{8{ins[7]}}, ins[7:0]};
    e_disp   = {{8{ins[7]}}, ins[7:0]};
    e_kind = 0; e_reg_we = 0; e_reg_en = '0; e_pc_mux = 0; e_pc_load = 0; e_ill = 0;
    if (hi == 4'h4 && ex == 4'h4) e_kind = 1;
    else if (hi == 4'h4 && ex == 4'h0) begin
      e_kind = 2;
      e_reg_en = 16'h0001 << ins[11:8];
    end else if (hi == 4'hC) e_pc_mux = taken_ref(ins[11:8], fl);
    else if (hi == 4'h4) begin
      if (ex == 4'hC) e_pc_load = taken_ref(ins[11:8], fl);
      else            e_ill = 1;
    end else if (e_op != 4'h0 && e_op != 4'hB) begin
      e_reg_we = 1;
      e_reg_en = 16'h0001 << ins[11:8];
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_mem_req"}, bus.mem_req, 0);
    chk({tag, "_mem_we"}, bus.mem_we, 0);
    chk({tag, "_ls_ctrl"}, bus.ls_ctrl, 0);
    chk({tag, "_ir_en"}, ir_en, 0);
    chk({tag, "_pc_en"}, pc_en, 0);
    chk({tag, "_reg_we"}, reg_we, 0);
    chk({tag, "_reg_en"}, reg_en, 0);
    chk({tag, "_halted"}, halted, 0);
    chk({tag, "_illegal"}, illegal, 0);
    chk({tag, "_count"}, instr_count, 0);
  endtask

  task automatic leave_halt(input bit use_step);
    if (m_hold) begin
      repeat (2) begin
        dbg_halt = 1'b0;
        dbg_step = 1'b0;
        @(negedge clk);
        chk("pause_hold_halted", halted, 1);
        chk("pause_hold_mem_req", bus.mem_req, 0);
        tick();
      end
    end
    if (m_hold || use_step) begin
      dbg_step = 1'b1;
      m_step   = 1;
    end else begin
      dbg_halt = 1'b0;
      m_step   = 0;
    end
    @(negedge clk);
    chk("halt_halted", halted, 1);
    chk("halt_pc_en", pc_en, 0);
    chk("halt_count", instr_count, m_count);
    tick();
    dbg_step = 1'b0;
    m_halted = 0;
  endtask

  task automatic run_instr(input logic [15:0] ins, input logic [4:0] fl,
                           input int wf, input int wd, input bit use_step);
    int d0, d1, ret_k;
    if (m_halted) leave_halt(use_step);
    predict(ins, fl);
    bus.instr  = ins;
    bus.ir_reg = ins;
    flags      = fl;
    d0 = wf + 2;
    d1 = wf + 2 + wd;
    ret_k = (e_kind == 0) ? wf + 2 : (e_kind == 1) ? d1 : d1 + 1;
    for (int k = 0; k <= ret_k; k++) begin
      bit in_f, in_d;
      in_f = (k <= wf);
      in_d = (e_kind != 0) && (k >= d0) && (k <= d1);
      bus.mem_ready = in_f ? (k == wf) : in_d ? (k == d1) : 1'($urandom % 2);
      @(negedge clk);
      if (k == 0) begin
        chk("count", instr_count, m_count);
        chk("illegal", illegal, m_ill);
        chk("run_halted", halted, 0);
      end
      chk("mem_req", bus.mem_req, in_f || in_d);
      chk("ir_en", ir_en, in_f);
      chk("ls_ctrl", bus.ls_ctrl, in_d);
      chk("mem_we", bus.mem_we, in_d && e_kind == 1);
      chk("pc_en", pc_en, k == ret_k);
      if (k == wf + 1) begin
        chk("dec_rsrc", rsrc, ins[3:0]);
        chk("dec_rdest", rdest, ins[11:8]);
      end
      if (in_d && e_kind == 2) chk("lda_rsrc", rsrc, ins[3:0]);
      if (k == ret_k) begin
        if (e_kind == 0) begin
          chk("op", op, e_op);
          chk("imm", imm, e_imm);
          chk("imm_en", imm_en, e_imm_en);
          chk("reg_we", reg_we, e_reg_we);
          chk("reg_en", reg_en, e_reg_en);
          chk("pc_mux_ctrl", pc_mux_ctrl, e_pc_mux);
          chk("pc_load", pc_load, e_pc_load);
          if (e_pc_mux) chk("disp", disp, e_disp);
          chk("alu_mux_ctrl", alu_mux_ctrl, 0);
        end else if (e_kind == 2) begin
          chk("ldwb_rdest", rdest, ins[11:8]);
          chk("ldwb_alu_mux", alu_mux_ctrl, 1);
          chk("ldwb_reg_we", reg_we, 1);
          chk("ldwb_reg_en", reg_en, e_reg_en);
        end else begin
          chk("st_reg_we", reg_we, 0);
        end
      end
      tick();
    end
    m_count++;
    if (e_ill) m_ill = 1;
    m_halted = dbg_halt || (m_count == PA) || m_step;
    if (m_count == PA) m_hold = 1;
    m_step = 0;
  endtask

  function automatic logic [15:0] gen_instr();
    logic [3:0] his [13] = '{4'h1, 4'h2, 4'h3, 4'h5, 4'h6, 4'h7, 4'h8, 4'h9,
                              4'hA, 4'hB, 4'hD, 4'hE, 4'hF};
    logic [3:0] bad [13] = '{4'h1, 4'h2, 4'h3, 4'h5, 4'h6, 4'h7, 4'h8, 4'h9,
                              4'hA, 4'hB, 4'hD, 4'hE, 4'hF};
    logic [15:0] r;
    r = 16'($urandom);
    case ($urandom % 7)
      0: r[15:12] = 4'h0;
      1: r[15:12] = his[$urandom % 13];
      2: r[15:12] = 4'hC;
      3: begin r[15:12] = 4'h4; r[7:4] = 4'hC; end
      4: begin r[15:12] = 4'h4; r[7:4] = 4'h0; end
      5: begin r[15:12] = 4'h4; r[7:4] = 4'h4; end
      default: begin r[15:12] = 4'h4; r[7:4] = bad[$urandom % 13]; end
    endcase
    return r;
  endfunction

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit hit, got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    m_count = 0; m_ill = 0; m_hold = 0; m_halted = 0; m_step = 0;
    reset = 1'b0; dbg_halt = 1'b0; dbg_step = 1'b0; flags = '0;
    bus.mem_ready = 1'b0; bus.instr = '0; bus.ir_reg = '0;
    #3;
    check_reset_outputs("rst");
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;

    // ADDI r3,#0xFF, halted at retire by dbg_halt, released afterwards
    dbg_halt = 1'b1;
    run_instr(16'h53FF, 5'h00, 0, 0, 0);
    run_instr(16'h1180, 5'h00, 1, 0, 0);   // ANDI r1,#0x80
    run_instr(16'h02B3, 5'h1F, 0, 0, 0);   // CMP r2,r3 -> third retire pauses
    run_instr(16'hC0FE, 5'h10, 0, 0, 1);   // BEQ with Z=1 via single step
    run_instr(16'hC0FE, 5'h0F, 0, 0, 1);   // BEQ with Z=0
    run_instr(16'h4402, 5'h00, 1, 2, 1);   // LOAD r4,(r2) with two wait states
    run_instr(16'h4543, 5'h00, 0, 1, 1);   // STORE with one wait state

    for (int i = 0; i < 150; i++) begin
      dbg_halt = 1'($urandom % 2);
      run_instr(gen_instr(), 5'($urandom), $urandom % 3, $urandom % 3, 1'($urandom % 2));
    end

    run_instr(16'h4170, 5'h00, 0, 0, 1);   // undefined extension
    if (m_halted) leave_halt(1);

    // reset asserted while held in LD_ADDR
    bus.instr = 16'h4402; bus.ir_reg = 16'h4402; flags = '0; dbg_halt = 1'b0;
    bus.mem_ready = 1'b1;
    tick();
    bus.mem_ready = 1'b0;
    tick();
    tick();
    @(negedge clk);
    chk("pre_rst_ls_ctrl", bus.ls_ctrl, 1);
    reset = 1'b0;
    #1;
    check_reset_outputs("midrst");
    tick();
    reset = 1'b1;
    @(negedge clk);
    chk("post_rst_mem_req", bus.mem_req, 1);
    chk("post_rst_ir_en", ir_en, 1);
    m_count = 0; m_ill = 0; m_hold = 0; m_halted = 0; m_step = 0;
    tick();

    for (int i = 0; i < 8; i++) begin
      dbg_halt = 1'($urandom % 2);
      run_instr(gen_instr(), 5'($urandom), $urandom % 3, $urandom % 3, 1'($urandom % 2));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
